// File: rtl/wave_capture_buf_pkg.sv
// Shared types and default geometry for the triggered waveform capture buffer.
package wave_cap_pkg;

    localparam int unsigned DEPTH_DEF        = 300;
    localparam int unsigned DW_DEF           = 8;
    localparam int unsigned AW_DEF           = 9;
    localparam int unsigned AUTO_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/wave_capture_buf_dpram.sv
// Ping-pong sample store: two banks addressed as {bank, addr}, one write port,
// one read port with a registered output so it maps onto block RAM.
module wave_dpram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 9
) (
    input  logic          vga_clk,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW:0]   rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(2**(AW+1))-1];

    always_ff @(posedge vga_clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/wave_capture_buf.sv
// Triggered capture of DEPTH post-trigger samples into the hidden bank of a
// ping-pong RAM; banks swap only on frame_start so a displayed trace is stable.
module wave_capture_buf
    import wave_cap_pkg::*;
#(
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
    input  logic          vga_clk,
    input  logic          sys_rst_n,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_fall,
    input  logic          auto_trig_en,
    input  logic          frame_start,
    input  logic [11:0]   pix_x,
    output logic [DW-1:0] wave_rd_data,
    output logic          capture_done,
    output logic          trig_locked
);

    localparam int unsigned    CW        = (AUTO_TIMEOUT > 2) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(AUTO_TIMEOUT - 1);
    localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [11:0]    PIX_LIMIT = 12'(DEPTH);

    cap_state_t    state;
    logic          disp_bank;
    logic          disp_valid;
    logic          prev_valid;
    logic          pend_locked;
    logic [DW-1:0] prev;
    logic [CW-1:0] auto_cnt;
    logic [AW-1:0] wr_addr;
    logic          rd_ok;
    logic [DW-1:0] ram_q;

    logic          hit;
    logic          forced;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;

    always_comb begin
        hit = 1'b0;
        if (prev_valid) begin
            if (trig_fall)
                hit = (prev > trig_level) && (adc_data <= trig_level);
            else
                hit = (prev < trig_level) && (adc_data >= trig_level);
        end
        forced    = auto_trig_en && (auto_cnt == CNT_LAST) && !hit;
        ram_we    = adc_valid && (((state == ARM) && (hit || forced)) || (state == CAPTURE));
        // The triggering sample always lands at address 0, even though wr_addr is already 0 in ARM.
        ram_waddr = (state == CAPTURE) ? wr_addr : '0;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ARM;
            disp_bank    <= 1'b0;
            disp_valid   <= 1'b0;
            prev_valid   <= 1'b0;
            pend_locked  <= 1'b0;
            prev         <= '0;
            auto_cnt     <= '0;
            wr_addr      <= '0;
            capture_done <= 1'b0;
            trig_locked  <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (adc_valid) begin
                        prev       <= adc_data;
                        prev_valid <= 1'b1;
                        if (auto_cnt != CNT_LAST)
                            auto_cnt <= auto_cnt + 1'b1;
                        if (hit || forced) begin
                            wr_addr     <= AW'(1);
                            pend_locked <= hit;
                            state       <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (adc_valid) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (wr_addr == ADDR_LAST) begin
                            state        <= DONE;
                            capture_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (frame_start) begin
                        disp_bank    <= ~disp_bank;
                        disp_valid   <= 1'b1;
                        trig_locked  <= pend_locked;
                        prev_valid   <= 1'b0;
                        auto_cnt     <= '0;
                        wr_addr      <= '0;
                        capture_done <= 1'b0;
                        state        <= ARM;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

    // Out-of-window columns and a never-filled display are masked alongside the RAM latency.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            rd_ok <= 1'b0;
        else
            rd_ok <= disp_valid && (pix_x < PIX_LIMIT);
    end

    always_comb begin
        wave_rd_data = rd_ok ? ram_q : '0;
    end

    wave_dpram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .vga_clk (vga_clk),
        .wr_en   (ram_we),
        .wr_addr ({~disp_bank, ram_waddr}),
        .wr_data (adc_data),
        .rd_addr ({disp_bank, pix_x[AW-1:0]}),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_wave_capture_buf.sv
// Randomized bench for wave_capture_buf against a queue-based model of the
// arm / capture / frame-swap behaviour.
module tb_wave_capture_buf;

    localparam int DEPTH = 300;
    localparam int ATO   = 1024;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic [7:0]  trig_level;
    logic        trig_fall;
    logic        auto_trig_en;
    logic        frame_start;
    logic [11:0] pix_x;
    logic [7:0]  wave_rd_data;
    logic        capture_done;
    logic        trig_locked;

    always #5 vga_clk = ~vga_clk;

    wave_capture_buf #(
        .DEPTH        (300),
        .DW           (8),
        .AW           (9),
        .AUTO_TIMEOUT (1024)
    ) dut (
        .vga_clk      (vga_clk),
        .sys_rst_n    (sys_rst_n),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .trig_level   (trig_level),
        .trig_fall    (trig_fall),
        .auto_trig_en (auto_trig_en),
        .frame_start  (frame_start),
        .pix_x        (pix_x),
        .wave_rd_data (wave_rd_data),
        .capture_done (capture_done),
        .trig_locked  (trig_locked)
    );

    int total = 0;
    int bad   = 0;

    // reference model: 0 = arming, 1 = collecting, 2 = full and waiting for a frame
    int         m_mode;
    int         m_arm_cnt;
    bit         m_have_prev;
    logic [7:0] m_prev;
    logic [7:0] m_cap[$];
    logic [7:0] m_disp[DEPTH];
    bit         m_disp_valid;
    bit         m_locked;
    bit         m_pend;

    int px_list[5]  = '{0, 127, 128, 299, 300};
    int exp_list[5] = '{128, 255, 0, 171, 0};

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] rnd_px();
        return 12'($urandom_range(0, 400));
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_arm_cnt    = 0;
        m_have_prev  = 0;
        m_prev       = '0;
        m_cap.delete();
        m_disp_valid = 0;
        m_locked     = 0;
        m_pend       = 0;
    endtask

    task automatic model_sample(input logic [7:0] d);
        bit hit, forced;
        if (m_mode == 0) begin
            hit = 0;
            if (m_have_prev)
                hit = trig_fall ? (m_prev > trig_level && d <= trig_level)
                                : (m_prev < trig_level && d >= trig_level);
            // counter saturates at its terminal value, so "at least" covers a late enable
            forced = !hit && auto_trig_en && (m_arm_cnt >= ATO - 1);
            m_arm_cnt++;
            m_prev      = d;
            m_have_prev = 1;
            if (hit || forced) begin
                m_cap.delete();
                m_cap.push_back(d);
                m_pend = hit;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_cap.push_back(d);
            if (m_cap.size() == DEPTH)
                m_mode = 2;
        end
    endtask

    task automatic model_swap();
        for (int i = 0; i < DEPTH; i++)
            m_disp[i] = m_cap[i];
        m_disp_valid = 1;
        m_locked     = m_pend;
        m_mode       = 0;
        m_arm_cnt    = 0;
        m_have_prev  = 0;
    endtask

    // one clock: drive at a falling edge, let the rising edge act, check at the next falling edge
    task automatic step(input logic v, input logic [7:0] d, input logic fs, input logic [11:0] px);
        int exp_rd;
        int mode_now;
        adc_valid   = v;
        adc_data    = d;
        frame_start = fs;
        pix_x       = px;
        exp_rd   = (m_disp_valid && px < DEPTH) ? int'(m_disp[px]) : 0;
        mode_now = m_mode;
        @(negedge vga_clk);
        if (fs && mode_now == 2)
            model_swap();
        else if (v)
            model_sample(d);
        check_eq("rd_data", wave_rd_data, exp_rd);
        check_eq("capture_done", capture_done, int'(m_mode == 2));
        check_eq("trig_locked", trig_locked, int'(m_locked));
    endtask

    task automatic feed(input logic [7:0] d, input int gap_max);
        step(1'b1, d, 1'b0, rnd_px());
        repeat ($urandom_range(0, gap_max))
            step(1'b0, 8'($urandom), 1'b0, rnd_px());
    endtask

    task automatic frame();
        step(1'b0, 8'($urandom), 1'b1, rnd_px());
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        check_eq("rst_rd_data", wave_rd_data, 0);
        check_eq("rst_capture_done", capture_done, 0);
        check_eq("rst_trig_locked", trig_locked, 0);
        model_reset();
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic randomize_trigger();
        trig_level   = 8'($urandom_range(40, 215));
        trig_fall    = 1'($urandom);
        auto_trig_en = 1'b1;
    endtask

    // feed random samples until the model is full, bounded so a stuck DUT cannot hang the run
    task automatic capture_full(input string tag);
        int n = 0;
        while (m_mode != 2 && n < 4000) begin
            feed(8'($urandom), 2);
            n++;
        end
        check_eq(tag, m_mode, 2);
    endtask

    initial begin
        sys_rst_n    = 1'b0;
        adc_data     = '0;
        adc_valid    = 1'b0;
        trig_level   = 8'd128;
        trig_fall    = 1'b0;
        auto_trig_en = 1'b0;
        frame_start  = 1'b0;
        pix_x        = '0;
        model_reset();
        repeat (3) @(negedge vga_clk);
        check_eq("init_rd_data", wave_rd_data, 0);
        check_eq("init_capture_done", capture_done, 0);
        check_eq("init_trig_locked", trig_locked, 0);
        sys_rst_n = 1'b1;

        // idle: no samples, three frames, display stays blank
        for (int f = 0; f < 3; f++) begin
            repeat (50) step(1'b0, 8'($urandom), 1'b0, rnd_px());
            frame();
        end

        // ramp, one sample every two clocks, rising trigger at 128
        trig_level   = 8'd128;
        trig_fall    = 1'b0;
        auto_trig_en = 1'b0;
        for (int i = 0; i < 128 + DEPTH; i++) begin
            step(1'b1, 8'(i % 256), 1'b0, rnd_px());
            step(1'b0, 8'($urandom), 1'b0, rnd_px());
        end
        check_eq("ramp_done", capture_done, 1);
        frame();
        check_eq("ramp_locked", trig_locked, 1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 8'h00, 1'b0, 12'(px_list[k]));
            check_eq("ramp_px", wave_rd_data, exp_list[k]);
        end

        // constant input, auto trigger after the timeout
        begin
            int first = 0;
            trig_level   = 8'($urandom);
            auto_trig_en = 1'b1;
            for (int n = 1; n <= 1400 && first == 0; n++) begin
                feed(8'h40, 1);
                if (capture_done)
                    first = n;
            end
            check_eq("auto_done_at", first, ATO + DEPTH - 1);
            frame();
            check_eq("auto_locked", trig_locked, 0);
            for (int p = 0; p < DEPTH; p++) begin
                step(1'b0, 8'h00, 1'b0, 12'(p));
                check_eq("auto_px", wave_rd_data, 8'h40);
            end
        end

        // constant input without auto trigger never captures
        @(negedge vga_clk);
        do_reset();
        auto_trig_en = 1'b0;
        begin
            logic [7:0] c = 8'($urandom);
            trig_level = 8'($urandom);
            for (int f = 0; f < 5; f++) begin
                repeat (100) feed(c, 1);
                frame();
                check_eq("noauto_done", capture_done, 0);
                check_eq("noauto_rd", wave_rd_data, 0);
            end
        end

        // frame_start on the final write must not swap
        randomize_trigger();
        capture_full("prefill_timeout");
        frame();
        randomize_trigger();
        begin
            int n = 0;
            while (!(m_mode == 1 && m_cap.size() == DEPTH - 1) && n < 4000) begin
                feed(8'($urandom), 2);
                n++;
            end
            check_eq("last_write_reached", int'(m_cap.size()), DEPTH - 1);
            step(1'b1, 8'($urandom), 1'b1, rnd_px());
            check_eq("last_write_done", capture_done, 1);
            repeat (20) step(1'b0, 8'($urandom), 1'b0, rnd_px());
            step(1'b0, 8'($urandom), 1'b1, 12'($urandom_range(0, DEPTH - 1)));
            check_eq("late_swap_done", capture_done, 0);
            repeat (40) step(1'b0, 8'($urandom), 1'b0, rnd_px());
        end

        // reset in the middle of a capture
        randomize_trigger();
        begin
            int n = 0;
            while (!(m_mode == 1 && m_cap.size() == 150) && n < 4000) begin
                feed(8'($urandom), 1);
                n++;
            end
            check_eq("midcap_reached", int'(m_cap.size()), 150);
        end
        do_reset();
        repeat (30) step(1'b0, 8'($urandom), 1'b0, rnd_px());
        frame();
        randomize_trigger();
        capture_full("recap_timeout");
        repeat (10) step(1'b0, 8'($urandom), 1'b0, rnd_px());
        frame();
        repeat (60) step(1'b0, 8'($urandom), 1'b0, rnd_px());

        // soak: random settings, gaps and frame pulses
        for (int r = 0; r < 4; r++) begin
            trig_level   = 8'($urandom);
            trig_fall    = 1'($urandom);
            auto_trig_en = 1'($urandom);
            for (int c = 0; c < 2500; c++) begin
                if ($urandom_range(0, 149) == 0)
                    frame();
                else
                    step(1'($urandom), 8'($urandom), 1'b0, rnd_px());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
